adsr_envelope_core: RTL

ADSR_ENVELOPE_CORE -- requirements
Module: adsr_envelope_core

---
 rtl/adsr_envelope_core.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/adsr_envelope_core.sv
// rtl/adsr_envelope_core.sv - ADSR envelope generator stepped once per audio sample tick
module adsr_envelope_core #(
  parameter int ENV_W  = 16,
  parameter int RATE_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              sample_tick,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_step,
  input  logic [RATE_W-1:0] decay_step,
  input  logic [RATE_W-1:0] release_step,
  input  logic [ENV_W-1:0]  sustain_level,
  output logic [ENV_W-1:0]  env_out,
  output logic              env_valid,
  output logic [2:0]        stage,
  output logic              active
);

  // One spare bit above the wider operand so sums never wrap before comparison.
  localparam int CALC_W = ((ENV_W > RATE_W) ? ENV_W : RATE_W) + 1;
  localparam logic [CALC_W-1:0] ENV_MAX = CALC_W'({ENV_W{1'b1}});

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_t;

  stage_t            state_q;
  stage_t            state_d;
  logic [ENV_W-1:0]  env_d;
  logic              gate_d;
  logic              retrig_pend;
  logic              gate_rise;
  logic              trigger;

  logic [CALC_W-1:0] env_x;
  logic [CALC_W-1:0] sus_x;
  logic [CALC_W-1:0] att_x;
  logic [CALC_W-1:0] dec_x;
  logic [CALC_W-1:0] rel_x;
  logic [CALC_W-1:0] att_sum;
  logic [CALC_W-1:0] dec_floor;

  assign gate_rise = gate & ~gate_d;
  // A rise landing on the tick cycle itself still triggers on that tick.
  assign trigger   = retrig_pend | gate_rise;

  assign env_x     = CALC_W'(env_out);
  assign sus_x     = CALC_W'(sustain_level);
  assign att_x     = CALC_W'(attack_step);
  assign dec_x     = CALC_W'(decay_step);
  assign rel_x     = CALC_W'(release_step);
  assign att_sum   = env_x + att_x;
  assign dec_floor = sus_x + dec_x;

  // Gate edge detection; a rise is remembered until the next sample tick consumes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      gate_d      <= 1'b0;
      retrig_pend <= 1'b0;
    end else begin
      gate_d <= gate;
      if (sample_tick) begin
        retrig_pend <= 1'b0;
      end else if (gate_rise) begin
        retrig_pend <= 1'b1;
      end
    end
  end

  // Next stage/level for the coming tick: trigger, then gate release, then stage stepping.
  always_comb begin
    state_d = state_q;
    env_d   = env_out;
    if (trigger) begin
      // Legato: the attack resumes from wherever the level currently is.
      state_d = ST_ATTACK;
    end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                           state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_ATTACK: begin
          if (attack_step == '0 || att_sum >= ENV_MAX) begin
            env_d   = ENV_MAX[ENV_W-1:0];
            state_d = ST_DECAY;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_step == '0 || env_x <= dec_floor) begin
            env_d   = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            // env > sustain + step here, so the step fits in ENV_W bits.
            env_d = env_out - dec_x[ENV_W-1:0];
          end
        end
        ST_SUSTAIN: begin
          env_d = sustain_level;
        end
        ST_RELEASE: begin
          if (release_step == '0 || env_x <= rel_x) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else begin
            env_d = env_out - rel_x[ENV_W-1:0];
          end
        end
        ST_IDLE: begin
          env_d = '0;
        end
        default: begin
          env_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Envelope state and registered outputs; everything advances only on sample_tick.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      env_out   <= '0;
      env_valid <= 1'b0;
      stage     <= 3'd0;
      active    <= 1'b0;
    end else begin
      env_valid <= sample_tick;
      if (sample_tick) begin
        state_q <= state_d;
        env_out <= env_d;
        stage   <= state_d;
        active  <= (state_d != ST_IDLE);
      end
    end
  end

endmodule
